// File: rtl/card_shoe_dealer.sv
// Card shoe: NUM_DECKS decks in RAM, LFSR-driven Fisher-Yates shuffle, one card per deal request.
// Optional cut card behaviour is enabled by defining CARD_SHOE_CUT_CARD_EN.
module card_shoe_dealer #(
  parameter int unsigned NUM_DECKS = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       shuffle,
  input  logic       round_start,
  output logic [3:0] cards,
  output logic       card_valid,
  output logic       ready,
  output logic [7:0] cards_left,
  output logic       cut_reached
);

  localparam int unsigned N     = 52 * NUM_DECKS;
  localparam int unsigned IW    = $clog2(N);
  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [IW-1:0] NLAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE   = IW'(1);
  localparam logic [7:0]    N8    = 8'(N);

  typedef enum logic [1:0] {StInit, StShuffle, StReady} state_e;

  state_e        state_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_next;
  logic [IW-1:0] idx_q;    // INIT write index, SHUFFLE position i
  logic [3:0]    rank_q;   // k mod 13 during INIT
  logic          phase_q;  // 0: read pair, 1: write swapped pair
  logic [IW-1:0] j_q;
  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic [IW-1:0] ptr_q;
  logic [3:0]    deck [N];

  logic [IW-1:0] idx_p1;
  logic [IW+7:0] shuffle_prod;
  logic [IW-1:0] j;
  logic [7:0]    unused_prod_lo;
  logic [3:0]    init_code;
  logic          reshuffle_req;
  logic          deal_fire;
  logic          cut_set;

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  // j = (lfsr[15:8] * (i+1)) >> 8 always lands in 0..i
  assign idx_p1         = idx_q + ONE;
  assign shuffle_prod   = {{IW{1'b0}}, lfsr_q[15:8]} * {8'd0, idx_p1};
  assign j              = shuffle_prod[IW+7:8];
  assign unused_prod_lo = shuffle_prod[7:0];

  always_comb begin
    init_code = 4'd11;
    if (rank_q == 4'd0) begin
      init_code = 4'd10;
    end else if (rank_q <= 4'd8) begin
      init_code = rank_q + 4'd1;
    end
  end

`ifdef CARD_SHOE_CUT_CARD_EN
  localparam logic [IW-1:0] CUT_LAST = IW'((3 * N) / 4 - 1);
  assign reshuffle_req = shuffle | (round_start & cut_reached);
  assign cut_set       = deal_fire && (ptr_q == CUT_LAST);
`else
  logic unused_round_start;
  assign unused_round_start = round_start;
  assign reshuffle_req      = shuffle;
  assign cut_set            = 1'b0;
`endif

  assign deal_fire = (state_q == StReady) && !reshuffle_req && deal_req && (cards_left != 8'd0);

  // Deck storage has no reset; INIT rebuilds it after every reset.
  always_ff @(posedge clock) begin
    if (state_q == StInit) begin
      deck[idx_q] <= init_code;
    end else if (state_q == StShuffle && phase_q) begin
      deck[idx_q] <= b_q;
      deck[j_q]   <= a_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StInit;
      lfsr_q      <= SEED;
      idx_q       <= '0;
      rank_q      <= 4'd0;
      phase_q     <= 1'b0;
      j_q         <= '0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      ptr_q       <= '0;
      cards       <= 4'd0;
      card_valid  <= 1'b0;
      ready       <= 1'b0;
      cards_left  <= 8'd0;
      cut_reached <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_next;
      cards      <= 4'd0;
      card_valid <= 1'b0;
      if (cut_set) begin
        cut_reached <= 1'b1;
      end
      case (state_q)
        StInit: begin
          rank_q <= (rank_q == 4'd12) ? 4'd0 : rank_q + 4'd1;
          if (idx_q == NLAST) begin
            state_q <= StShuffle;
            phase_q <= 1'b0;
          end else begin
            idx_q <= idx_q + ONE;
          end
        end
        StShuffle: begin
          if (!phase_q) begin
            j_q     <= j;
            a_q     <= deck[idx_q];
            b_q     <= deck[j];
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (idx_q == ONE) begin
              state_q     <= StReady;
              ptr_q       <= '0;
              cards_left  <= N8;
              ready       <= 1'b1;
              cut_reached <= 1'b0;
            end else begin
              idx_q <= idx_q - ONE;
            end
          end
        end
        StReady: begin
          if (reshuffle_req) begin
            state_q    <= StShuffle;
            idx_q      <= NLAST;
            phase_q    <= 1'b0;
            ready      <= 1'b0;
            cards_left <= 8'd0;
          end else if (deal_fire) begin
            cards      <= deck[ptr_q];
            card_valid <= 1'b1;
            ptr_q      <= ptr_q + ONE;
            cards_left <= cards_left - 8'd1;
            if (cards_left == 8'd1) begin
              state_q <= StShuffle;
              idx_q   <= NLAST;
              phase_q <= 1'b0;
              ready   <= 1'b0;
            end
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe_dealer.sv
// Directed self-checking bench for card_shoe_dealer (NUM_DECKS=1).
// Honours CARD_SHOE_CUT_CARD_EN to pick the expected cut-card behaviour.
module tb_card_shoe_dealer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       deal_req = 1'b0;
  logic       shuffle = 1'b0;
  logic       round_start = 1'b0;
  logic [3:0] cards;
  logic       card_valid;
  logic       ready;
  logic [7:0] cards_left;
  logic       cut_reached;

  int tests = 0;
  int fails = 0;
  logic [3:0] perm1 [52];
  logic [3:0] perm2 [52];
  logic [3:0] perm3 [52];

`ifdef CARD_SHOE_CUT_CARD_EN
  localparam int CutAt = 39;
`else
  localparam int CutAt = 1000;
`endif

  card_shoe_dealer #(.NUM_DECKS(1), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .deal_req(deal_req), .shuffle(shuffle),
    .round_start(round_start), .cards(cards), .card_valid(card_valid), .ready(ready),
    .cards_left(cards_left), .cut_reached(cut_reached)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Waits for ready, optionally poking requests that must be ignored meanwhile.
  task automatic wait_ready(input int limit, input bit poke_deal, input bit poke_shuffle,
                            output int n);
    int bad;
    bad = 0;
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      if (card_valid !== 1'b0 || cards !== 4'd0) bad++;
      if (ready === 1'b1) begin
        n = c;
        break;
      end
      deal_req = poke_deal;
      shuffle  = poke_shuffle;
    end
    deal_req = 1'b0;
    shuffle  = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_no_card: %0d cycles had card_valid/cards nonzero, required 0", bad);
    end
    if (n > 0) begin
      tests++;
      if (cut_reached !== 1'b0) begin
        fails++;
        $display("FAIL cut_after_shuffle: cut_reached=%b, required 0", cut_reached);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0; shuffle = 1'b1; deal_req = 1'b1;
    #23;
    tests++;
    if ({cards, card_valid, ready, cards_left, cut_reached} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: cards=%0d valid=%b ready=%b left=%0d cut=%b, required all 0",
               cards, card_valid, ready, cards_left, cut_reached);
    end
    @(negedge clock);
    reset = 1'b1;
    wait_ready(300, 1'b1, 1'b1, n);
    tests++;
    if (n != 154) begin
      fails++; $display("FAIL init_latency: ready after %0d cycles, required 154", n);
    end
    tests++;
    if (cards_left !== 8'd52) begin
      fails++; $display("FAIL init_left: cards_left=%0d, required 52", cards_left);
    end
  endtask

  task automatic test_deal_spaced(output logic [3:0] p [52]);
    for (int k = 0; k < 52; k++) begin
      deal_req = 1'b1;
      @(negedge clock);
      deal_req = 1'b0;
      p[k] = cards;
      tests++;
      if (card_valid !== 1'b1) begin
        fails++; $display("FAIL spaced_valid card %0d: valid=%b, required 1", k, card_valid);
      end
      tests++;
      if (cards_left !== 8'(51 - k)) begin
        fails++; $display("FAIL spaced_left card %0d: %0d, required %0d", k, cards_left, 51 - k);
      end
      tests++;
      if (ready !== (k != 51)) begin
        fails++; $display("FAIL spaced_ready card %0d: ready=%b, required %b", k, ready, k != 51);
      end
      tests++;
      if (cut_reached !== (k + 1 >= CutAt)) begin
        fails++;
        $display("FAIL spaced_cut card %0d: cut=%b, required %b", k, cut_reached, k + 1 >= CutAt);
      end
      if (k != 51) begin
        @(negedge clock);
        tests++;
        if (card_valid !== 1'b0 || cards !== 4'd0) begin
          fails++;
          $display("FAIL strobe_width card %0d: valid=%b cards=%0d, required 0/0", k, card_valid,
                   cards);
        end
      end
    end
  endtask

  task automatic test_histogram(input logic [3:0] p [52]);
    int hist [16];
    int want;
    for (int c = 0; c < 16; c++) hist[c] = 0;
    for (int k = 0; k < 52; k++) hist[int'(p[k])]++;
    for (int c = 0; c < 16; c++) begin
      want = (c >= 2 && c <= 10) ? 4 : ((c == 11) ? 16 : 0);
      tests++;
      if (hist[c] != want) begin
        fails++; $display("FAIL histogram code %0d: count %0d, required %0d", c, hist[c], want);
      end
    end
  endtask

  task automatic test_empty_reshuffle();
    int n;
    wait_ready(200, 1'b1, 1'b0, n);
    tests++;
    if (n != 102) begin
      fails++; $display("FAIL empty_reshuffle_len: ready after %0d cycles, required 102", n);
    end
    tests++;
    if (cards_left !== 8'd52) begin
      fails++; $display("FAIL empty_reshuffle_left: %0d, required 52", cards_left);
    end
  endtask

  task automatic test_back_to_back(output logic [3:0] p [52]);
    deal_req = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge clock);
      if (k == 51) deal_req = 1'b0;
      p[k] = cards;
      tests++;
      if (card_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_valid card %0d: valid=%b, required 1", k, card_valid);
      end
      tests++;
      if (cards_left !== 8'(51 - k)) begin
        fails++; $display("FAIL b2b_left card %0d: %0d, required %0d", k, cards_left, 51 - k);
      end
      tests++;
      if (ready !== (k != 51)) begin
        fails++; $display("FAIL b2b_ready card %0d: ready=%b, required %b", k, ready, k != 51);
      end
      tests++;
      if (cut_reached !== (k + 1 >= CutAt)) begin
        fails++;
        $display("FAIL b2b_cut card %0d: cut=%b, required %b", k, cut_reached, k + 1 >= CutAt);
      end
    end
  endtask

  task automatic test_second_shoe();
    int n;
    int same;
    test_back_to_back(perm2);
    test_histogram(perm2);
    same = 0;
    for (int k = 0; k < 52; k++) if (perm2[k] === perm1[k]) same++;
    tests++;
    if (same == 52) begin
      fails++; $display("FAIL reshuffle_differs: %0d of 52 positions equal, required < 52", same);
    end
    wait_ready(200, 1'b0, 1'b0, n);
    tests++;
    if (n != 102) begin
      fails++; $display("FAIL second_reshuffle_len: %0d cycles, required 102", n);
    end
  endtask

  task automatic test_shuffle_priority();
    int n;
    shuffle = 1'b1; deal_req = 1'b1;
    @(negedge clock);
    shuffle = 1'b0; deal_req = 1'b0;
    tests++;
    if (card_valid !== 1'b0 || ready !== 1'b0 || cards_left !== 8'd0) begin
      fails++;
      $display("FAIL shuffle_wins: valid=%b ready=%b left=%0d, required 0/0/0", card_valid, ready,
               cards_left);
    end
    wait_ready(200, 1'b1, 1'b1, n);
    tests++;
    if (n != 102) begin
      fails++; $display("FAIL shuffle_len: ready after %0d cycles, required 102", n);
    end
    tests++;
    if (cards_left !== 8'd52) begin
      fails++; $display("FAIL shuffle_left: %0d, required 52", cards_left);
    end
  endtask

  task automatic test_reset_mid_deal();
    int n;
    deal_req = 1'b1;
    @(negedge clock);
    deal_req = 1'b0;
    tests++;
    if (card_valid !== 1'b1) begin
      fails++; $display("FAIL middeal_valid: valid=%b, required 1", card_valid);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({cards, card_valid, ready, cards_left, cut_reached} !== 15'd0) begin
      fails++;
      $display("FAIL middeal_reset: cards=%0d valid=%b ready=%b left=%0d cut=%b, required all 0",
               cards, card_valid, ready, cards_left, cut_reached);
    end
    @(negedge clock);
    reset = 1'b1;
    wait_ready(300, 1'b0, 1'b0, n);
    tests++;
    if (n != 154) begin
      fails++; $display("FAIL middeal_restart: ready after %0d cycles, required 154", n);
    end
  endtask

  task automatic test_reset_mid_shuffle();
    int n;
    int diff;
    shuffle = 1'b1;
    @(negedge clock);
    shuffle = 1'b0;
    repeat (50) @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if ({cards, card_valid, ready, cards_left, cut_reached} !== 15'd0) begin
      fails++;
      $display("FAIL midshuffle_reset: cards=%0d valid=%b ready=%b left=%0d, required all 0",
               cards, card_valid, ready, cards_left);
    end
    @(negedge clock);
    reset = 1'b1;
    wait_ready(300, 1'b0, 1'b0, n);
    tests++;
    if (n != 154) begin
      fails++; $display("FAIL midshuffle_restart: ready after %0d cycles, required 154", n);
    end
    test_back_to_back(perm3);
    diff = 0;
    for (int k = 0; k < 52; k++) if (perm3[k] !== perm1[k]) diff++;
    tests++;
    if (diff != 0) begin
      fails++; $display("FAIL seed_replay: %0d positions differ from first shoe, required 0", diff);
    end
    wait_ready(200, 1'b0, 1'b0, n);
    tests++;
    if (n != 102) begin
      fails++; $display("FAIL midshuffle_reshuffle_len: %0d cycles, required 102", n);
    end
  endtask

  task automatic test_cut_card();
    int n;
    round_start = 1'b1;
    @(negedge clock);
    round_start = 1'b0;
    tests++;
    if (ready !== 1'b1 || cards_left !== 8'd52) begin
      fails++;
      $display("FAIL early_round_start: ready=%b left=%0d, required 1/52", ready, cards_left);
    end
`ifdef CARD_SHOE_CUT_CARD_EN
    deal_req = 1'b1;
    for (int k = 0; k < 39; k++) begin
      @(negedge clock);
      if (k == 38) deal_req = 1'b0;
      tests++;
      if (cut_reached !== (k == 38)) begin
        fails++; $display("FAIL cut_rise card %0d: cut=%b, required %b", k, cut_reached, k == 38);
      end
    end
    @(negedge clock);
    tests++;
    if (cut_reached !== 1'b1 || cards_left !== 8'd13) begin
      fails++; $display("FAIL cut_hold: cut=%b left=%0d, required 1/13", cut_reached, cards_left);
    end
    round_start = 1'b1;
    @(negedge clock);
    round_start = 1'b0;
    tests++;
    if (ready !== 1'b0 || cards_left !== 8'd0 || cut_reached !== 1'b1) begin
      fails++;
      $display("FAIL cut_reshuffle_start: ready=%b left=%0d cut=%b, required 0/0/1", ready,
               cards_left, cut_reached);
    end
`else
    round_start = 1'b1;
    test_back_to_back(perm3);
    round_start = 1'b0;
`endif
    wait_ready(200, 1'b0, 1'b0, n);
    tests++;
    if (n != 102 || cards_left !== 8'd52) begin
      fails++;
      $display("FAIL cut_reshuffle: %0d cycles left=%0d, required 102/52", n, cards_left);
    end
  endtask

  initial begin
    test_reset();
    test_deal_spaced(perm1);
    test_histogram(perm1);
    test_empty_reshuffle();
    test_second_shoe();
    test_shuffle_priority();
    test_reset_mid_deal();
    test_reset_mid_shuffle();
    test_cut_card();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/card_shoe_dealer.md
Name: card_shoe_dealer

Overview:
Upstream card source for the blackjack state machine. It holds one or more shuffled 52-card decks in on-chip RAM, shuffles them with an LFSR-driven Fisher-Yates pass, and presents one card per deal request on the 4-bit `cards` bus. The bus reads 0 whenever no card is presented. It also tracks the number of cards remaining and reshuffles automatically when the shoe runs out.

Parameters:
NUM_DECKS, 1, number of 52-card decks in the shoe, legal range 1..4; N = 52*NUM_DECKS.
LFSR_SEED, 16'hACE1, reset value of the shuffle LFSR; a value of 0 is replaced by 16'h0001.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
deal_req  input  1  one-cycle request for the next card.
shuffle  input  1  one-cycle request to reshuffle the whole shoe.
round_start  input  1  pulse at the start of each hand; used only by the optional feature.
cards  output  4  card code, valid only while card_valid=1, otherwise 4'd0.
card_valid  output  1  one-cycle strobe that qualifies `cards`.
ready  output  1  1 when the shoe is in READY and can accept deal_req.
cards_left  output  8  number of undealt cards.
cut_reached  output  1  cut-card flag; see Optional Feature.

Behaviour:
- Card codes: 4'd2..4'd9 are pip cards, 4'd10 is the ace, 4'd11 is any ten-valued card (10/J/Q/K), 4'd0 means no card. Codes 1 and 12..15 are never emitted.
- Reset (reset=0, asynchronous):
  - Outputs: cards=0, card_valid=0, ready=0, cards_left=0, cut_reached=0.
  - Internal: LFSR=seed, deal pointer=0, state=INIT.
- LFSR: 16-bit Galois, tap mask 16'hB400. It advances every clock in every state, so the moment the player presses a button contributes entropy.
- States and transitions:
  - INIT
    - Writes deck[k] for k=0..N-1, one entry per cycle.
    - r = k mod 13: r=0 gives code 10; r=1..8 gives code r+1; r=9..12 gives code 11.
    - Then goes to SHUFFLE. INIT runs only after reset.
  - SHUFFLE
    - i runs from N-1 down to 1, two cycles per i.
    - Cycle A: j = (lfsr[15:8] * (i+1)) >> 8, giving 0 <= j <= i; read deck[i] and deck[j].
    - Cycle B: write the two entries swapped.
    - Total 2*(N-1) cycles. On exit: pointer=0, cards_left=N, go to READY.
  - READY
    - ready=1.
    - If deal_req=1 and cards_left>0: on the next cycle cards=deck[pointer] and card_valid=1 for exactly one cycle; the pointer increments and cards_left decrements on the same edge.
    - Back-to-back requests are served every cycle.
- Latency: 1 cycle from deal_req to card_valid.
- Empty shoe:
  - The edge that deals the last card sets cards_left=0, clears ready, and enters SHUFFLE.
  - The shoe reshuffles the existing array in place with no INIT.
- Requests outside READY:
  - deal_req while ready=0 is dropped, not queued; card_valid stays 0.
  - shuffle in INIT or SHUFFLE is ignored.
- shuffle in READY: next cycle ready=0, cards_left=0, state=SHUFFLE.
- shuffle and deal_req in the same cycle in READY: shuffle wins and no card is produced.
- Reset asserted mid-INIT, mid-SHUFFLE or mid-deal: all outputs clear immediately. After release the block restarts from INIT with LFSR=seed.
- Deck contents are always a permutation of the full N-card multiset.

Optional Feature:
Macro: CARD_SHOE_CUT_CARD_EN.
- Defined:
  - cut_reached rises on the edge where cards_dealt reaches 3N/4 (39 for one deck) and stays high.
  - The next round_start pulse in READY starts SHUFFLE, identical to a shuffle pulse.
  - cut_reached clears when SHUFFLE completes.
  - Dealing continues normally while cut_reached=1 until round_start arrives or the shoe empties.
- Not defined: cut_reached is tied to 0, round_start is ignored, and reshuffles occur only on shuffle or an empty shoe.

Test Plan:
1. Release reset, NUM_DECKS=1 -> ready rises exactly 52+102 cycles later; cards_left=52; cards=0 and card_valid=0 throughout.
2. 52 consecutive deal_req pulses -> 52 single-cycle card_valid strobes, each one cycle after its request. Histogram: four each of codes 2..9 and 10, sixteen of code 11. cards=0 whenever card_valid=0; cards_left counts 51..0.
3. After the last card -> ready=0 on the same edge; deal_req during the following 102 cycles gives no card_valid; then ready=1 and cards_left=52. The second permutation differs from the first.
4. shuffle and deal_req in the same cycle in READY -> no card_valid; ready=0 for 102 cycles; cards_left returns to 52.
5. reset=0 for one cycle midway through SHUFFLE -> all outputs 0 immediately; after release the full 154-cycle INIT+SHUFFLE repeats; LFSR sequence matches a fresh reset.
6. With CARD_SHOE_CUT_CARD_EN: after 39 deals cut_reached=1; a round_start pulse leads to reshuffle and cut_reached=0 with cards_left=52. Without the macro, cut_reached stays 0 and all 52 cards deal.
